// File: rtl/tuner_phy_pkg.sv
// Shared types and constants for the ring-tuner control slice.
// Contents:
//   tuner_search_state_e  state encoding of the search/sweep controller
//   SearchStepMin         smallest sweep increment; a programmed step of 0 maps here
package tuner_phy_pkg;

  typedef enum logic [2:0] {
    SEARCH_IDLE,
    SEARCH_REFRESH,
    SEARCH_TUNE,
    SEARCH_COMMIT,
    SEARCH_DONE
  } tuner_search_state_e;

  localparam int SearchStepMin = 1;

endpackage

// File: rtl/tuner_search_peak_track.sv
// Peak tracker for the tuner sweep: remembers the highest committed power and
// the code it was measured at.
// Ports:
//   i_clk, i_rst  clock, asynchronous active-high reset
//   clr           restart tracking; peak_pwr <= 0, peak_code <= code, no valid peak
//   upd           a committed (pwr, code) pair is presented
//   pwr           committed power
//   code          committed code on upd, sweep start code on clr
//   peak_pwr      highest power seen since clr
//   peak_code     code paired with peak_pwr
module tuner_search_peak_track #(
  parameter int ADC_WIDTH = 8,
  parameter int DAC_WIDTH = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 clr,
  input  logic                 upd,
  input  logic [ADC_WIDTH-1:0] pwr,
  input  logic [DAC_WIDTH-1:0] code,
  output logic [ADC_WIDTH-1:0] peak_pwr,
  output logic [DAC_WIDTH-1:0] peak_code
);

  logic peak_valid;
  logic take;

  // Strict compare so that a tie keeps the earlier code; the first commit
  // after clr always wins, even at power 0.
  assign take = upd && (!peak_valid || (pwr > peak_pwr));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      peak_pwr   <= '0;
      peak_code  <= '0;
      peak_valid <= 1'b0;
    end else if (clr) begin
      peak_pwr   <= '0;
      peak_code  <= code;
      peak_valid <= 1'b0;
    end else if (upd) begin
      peak_valid <= 1'b1;
      if (take) begin
        peak_pwr  <= pwr;
        peak_code <= code;
      end
    end
  end

endmodule

// File: rtl/tuner_ctrl_search_sweep.sv
// Ring-tuner search sweep. Steps the tuner DAC code across a programmed window,
// issuing one tune request per point on the arbiter tune/commit handshake and
// collecting the committed (code, power) pairs; the strongest pair is reported.
// Ports:
//   i_clk, i_rst              clock, asynchronous active-high reset
//   i_search_start/abort      start pulse (IDLE/DONE only) / abort to IDLE
//   i_code_start/end/step     sweep window, captured when a start is accepted
//   o_ctrl_active             power-detect enable (REFRESH, TUNE, COMMIT)
//   o_ctrl_refresh            one-cycle pulse at sweep start
//   o_ctrl_tune_val/_rdy      tune request handshake, o_ctrl_ring_tune = code
//   i_ctrl_commit_val/o_..rdy commit handshake carrying pwr and code
//   o_search_busy/done        sweep in progress / sweep finished
//   o_peak_pwr/code           strongest committed pair, live during the sweep
//
// state          | meaning
// SEARCH_IDLE    | waiting for start
// SEARCH_REFRESH | load code and window, clear peak, pulse refresh
// SEARCH_TUNE    | tune request for the current code outstanding
// SEARCH_COMMIT  | waiting for the commit of the current code
// SEARCH_DONE    | sweep finished, peak outputs final
module tuner_ctrl_search_sweep
  import tuner_phy_pkg::*;
#(
  parameter int DAC_WIDTH = 8,
  parameter int ADC_WIDTH = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_search_start,
  input  logic                 i_search_abort,
  input  logic [DAC_WIDTH-1:0] i_code_start,
  input  logic [DAC_WIDTH-1:0] i_code_end,
  input  logic [DAC_WIDTH-1:0] i_code_step,
  output logic                 o_ctrl_active,
  output logic                 o_ctrl_refresh,
  output logic                 o_ctrl_tune_val,
  input  logic                 i_ctrl_tune_rdy,
  output logic [DAC_WIDTH-1:0] o_ctrl_ring_tune,
  input  logic                 i_ctrl_commit_val,
  output logic                 o_ctrl_commit_rdy,
  input  logic [ADC_WIDTH-1:0] i_ctrl_pwr_commit,
  input  logic [DAC_WIDTH-1:0] i_ctrl_ring_tune_commit,
  output logic                 o_search_busy,
  output logic                 o_search_done,
  output logic [ADC_WIDTH-1:0] o_peak_pwr,
  output logic [DAC_WIDTH-1:0] o_peak_code
);

  tuner_search_state_e state_q, state_d;

  logic [DAC_WIDTH-1:0] code_q;
  logic [DAC_WIDTH-1:0] start_q;
  logic [DAC_WIDTH-1:0] end_q;
  logic [DAC_WIDTH-1:0] step_q;
  logic [DAC_WIDTH:0]   nxt;
  logic                 last;
  logic                 start_ok;
  logic                 tune_fire;
  logic                 commit_fire;
  logic                 peak_clr;
  logic                 peak_upd;
  logic [DAC_WIDTH-1:0] peak_code_in;

  assign start_ok    = i_search_start &&
                       ((state_q == SEARCH_IDLE) || (state_q == SEARCH_DONE));
  assign tune_fire   = (state_q == SEARCH_TUNE) && i_ctrl_tune_rdy;
  assign commit_fire = (state_q == SEARCH_COMMIT) && i_ctrl_commit_val;

  // One extra bit keeps the carry: a step past the top of the code range ends
  // the sweep instead of wrapping back to a low code.
  assign nxt  = {1'b0, code_q} + {1'b0, step_q};
  assign last = (nxt > {1'b0, end_q}) || (code_q >= end_q);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= SEARCH_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (i_search_abort) begin
      state_d = SEARCH_IDLE;
    end else begin
      case (state_q)
        SEARCH_IDLE:    if (start_ok) state_d = SEARCH_REFRESH;
        SEARCH_REFRESH: state_d = SEARCH_TUNE;
        SEARCH_TUNE:    if (tune_fire) state_d = SEARCH_COMMIT;
        SEARCH_COMMIT:  if (commit_fire) state_d = last ? SEARCH_DONE : SEARCH_TUNE;
        SEARCH_DONE:    if (start_ok) state_d = SEARCH_REFRESH;
        default:        state_d = SEARCH_IDLE;
      endcase
    end
  end

  // Handshake outputs decode the state register only, so the arbiter never
  // sees a combinational loop through val/rdy.
  assign o_ctrl_active     = (state_q == SEARCH_REFRESH) || (state_q == SEARCH_TUNE) ||
                             (state_q == SEARCH_COMMIT);
  assign o_ctrl_refresh    = (state_q == SEARCH_REFRESH);
  assign o_ctrl_tune_val   = (state_q == SEARCH_TUNE);
  assign o_ctrl_commit_rdy = (state_q == SEARCH_COMMIT);
  assign o_search_busy     = (state_q != SEARCH_IDLE) && (state_q != SEARCH_DONE);
  assign o_search_done     = (state_q == SEARCH_DONE);
  assign o_ctrl_ring_tune  = code_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      start_q <= '0;
      end_q   <= '0;
      step_q  <= '0;
    end else if (start_ok && !i_search_abort) begin
      start_q <= i_code_start;
      end_q   <= i_code_end;
      step_q  <= (i_code_step == '0) ? DAC_WIDTH'(SearchStepMin) : i_code_step;
    end
  end

  // The code register is left at the final point after the sweep ends.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      code_q <= '0;
    end else if (!i_search_abort) begin
      if (state_q == SEARCH_REFRESH) begin
        code_q <= start_q;
      end else if (commit_fire && !last) begin
        code_q <= nxt[DAC_WIDTH-1:0];
      end
    end
  end

  // A commit that coincides with abort is dropped so the peak survives intact.
  assign peak_clr     = (state_q == SEARCH_REFRESH) && !i_search_abort;
  assign peak_upd     = commit_fire && !i_search_abort;
  assign peak_code_in = peak_clr ? start_q : i_ctrl_ring_tune_commit;

  tuner_search_peak_track #(
    .ADC_WIDTH(ADC_WIDTH),
    .DAC_WIDTH(DAC_WIDTH)
  ) u_peak (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .clr      (peak_clr),
    .upd      (peak_upd),
    .pwr      (i_ctrl_pwr_commit),
    .code     (peak_code_in),
    .peak_pwr (o_peak_pwr),
    .peak_code(o_peak_code)
  );

endmodule

// File: tb/tb_tuner_ctrl_search_sweep.sv
// Self-checking bench for tuner_ctrl_search_sweep. Acts as the arbiter with
// random tune/commit latencies, powers come from a per-code lookup table, and
// the expected code list and peak are computed directly from the sweep rules.
module tb_tuner_ctrl_search_sweep;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_search_start, i_search_abort;
  logic [7:0] i_code_start, i_code_end, i_code_step;
  logic       o_ctrl_active, o_ctrl_refresh, o_ctrl_tune_val, i_ctrl_tune_rdy;
  logic [7:0] o_ctrl_ring_tune;
  logic       i_ctrl_commit_val, o_ctrl_commit_rdy;
  logic [7:0] i_ctrl_pwr_commit, i_ctrl_ring_tune_commit;
  logic       o_search_busy, o_search_done;
  logic [7:0] o_peak_pwr, o_peak_code;

  int vectors = 0;
  int miscompares = 0;
  int refresh_cnt = 0;
  int exp_refresh = 0;
  logic [7:0] pwr_tab [256];

  tuner_ctrl_search_sweep #(.DAC_WIDTH(8), .ADC_WIDTH(8)) dut (
    .i_clk                  (i_clk),
    .i_rst                  (i_rst),
    .i_search_start         (i_search_start),
    .i_search_abort         (i_search_abort),
    .i_code_start           (i_code_start),
    .i_code_end             (i_code_end),
    .i_code_step            (i_code_step),
    .o_ctrl_active          (o_ctrl_active),
    .o_ctrl_refresh         (o_ctrl_refresh),
    .o_ctrl_tune_val        (o_ctrl_tune_val),
    .i_ctrl_tune_rdy        (i_ctrl_tune_rdy),
    .o_ctrl_ring_tune       (o_ctrl_ring_tune),
    .i_ctrl_commit_val      (i_ctrl_commit_val),
    .o_ctrl_commit_rdy      (o_ctrl_commit_rdy),
    .i_ctrl_pwr_commit      (i_ctrl_pwr_commit),
    .i_ctrl_ring_tune_commit(i_ctrl_ring_tune_commit),
    .o_search_busy          (o_search_busy),
    .o_search_done          (o_search_done),
    .o_peak_pwr             (o_peak_pwr),
    .o_peak_code            (o_peak_code)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  always @(negedge i_clk) begin
    if (!i_rst) begin
      chk("tune_commit_exclusive", {31'd0, o_ctrl_tune_val & o_ctrl_commit_rdy}, 32'd0);
      if (o_ctrl_refresh) refresh_cnt++;
    end
  end

  task automatic fill_random_pwr(input int max_p);
    for (int i = 0; i < 256; i++) pwr_tab[i] = 8'($urandom_range(0, max_p));
  endtask

  task automatic wait_tune(output bit ok);
    int n = 0;
    while (!o_ctrl_tune_val && n < 20) begin
      tick();
      n++;
    end
    ok = o_ctrl_tune_val;
    if (!ok) chk("tune_val_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_sweep(input int s, input int e, input int st, input bit poke_start);
    int exp_q[$];
    int got_q[$];
    int stp, c, pk_p, pk_c, n;
    bit pv, ok;
    logic [7:0] code;
    stp = (st == 0) ? 1 : st;
    c = s;
    forever begin
      exp_q.push_back(c);
      if (c >= e || c + stp > e) break;
      c += stp;
    end
    pv = 1'b0; pk_p = 0; pk_c = s;
    foreach (exp_q[i]) begin
      if (!pv || int'(pwr_tab[exp_q[i]]) > pk_p) begin
        pk_p = int'(pwr_tab[exp_q[i]]);
        pk_c = exp_q[i];
      end
      pv = 1'b1;
    end

    i_code_start = 8'(s); i_code_end = 8'(e); i_code_step = 8'(st);
    i_search_start = 1'b1;
    tick();
    i_search_start = 1'b0;
    exp_refresh++;
    chk("refresh_pulse", {31'd0, o_ctrl_refresh}, 32'd1);
    chk("busy_in_refresh", {31'd0, o_search_busy}, 32'd1);
    tick();
    chk("refresh_one_cycle", {31'd0, o_ctrl_refresh}, 32'd0);

    while (!o_search_done && got_q.size() < exp_q.size() + 2) begin
      wait_tune(ok);
      if (!ok) break;
      code = o_ctrl_ring_tune;
      n = $urandom_range(0, 5);
      repeat (n) begin
        tick();
        chk("ring_tune_stable", {24'd0, o_ctrl_ring_tune}, {24'd0, code});
      end
      i_ctrl_tune_rdy = 1'b1;
      tick();
      i_ctrl_tune_rdy = 1'b0;
      got_q.push_back(int'(code));
      chk("commit_rdy_after_fire", {31'd0, o_ctrl_commit_rdy}, 32'd1);
      if (poke_start && got_q.size() == 1) begin
        i_search_start = 1'b1;
        tick();
        i_search_start = 1'b0;
      end
      n = $urandom_range(0, 5);
      repeat (n) tick();
      i_ctrl_commit_val = 1'b1;
      i_ctrl_ring_tune_commit = code;
      i_ctrl_pwr_commit = pwr_tab[code];
      tick();
      i_ctrl_commit_val = 1'b0;
    end

    chk("done_set", {31'd0, o_search_done}, 32'd1);
    chk("busy_clear", {31'd0, o_search_busy}, 32'd0);
    chk("num_points", got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk("tune_code", got_q[i], exp_q[i]);
    chk("peak_pwr", {24'd0, o_peak_pwr}, pk_p);
    chk("peak_code", {24'd0, o_peak_code}, pk_c);
  endtask

  initial begin
    bit ok;
    i_rst = 1'b1;
    i_search_start = 1'b0; i_search_abort = 1'b0;
    i_code_start = '0; i_code_end = '0; i_code_step = '0;
    i_ctrl_tune_rdy = 1'b0; i_ctrl_commit_val = 1'b0;
    i_ctrl_pwr_commit = '0; i_ctrl_ring_tune_commit = '0;
    fill_random_pwr(255);
    tick(); tick();
    chk("rst_active", {31'd0, o_ctrl_active}, 32'd0);
    chk("rst_tune_val", {31'd0, o_ctrl_tune_val}, 32'd0);
    chk("rst_busy", {31'd0, o_search_busy}, 32'd0);
    chk("rst_done", {31'd0, o_search_done}, 32'd0);
    chk("rst_ring_tune", {24'd0, o_ctrl_ring_tune}, 32'd0);
    chk("rst_peak_pwr", {24'd0, o_peak_pwr}, 32'd0);
    i_rst = 1'b0;
    tick();

    // basic window with a clear peak in the middle
    pwr_tab[10] = 8'd3; pwr_tab[15] = 8'd9; pwr_tab[20] = 8'd4;
    run_sweep(10, 20, 5, 1'b1);
    // top of range: carry terminates, no wrap
    run_sweep(250, 255, 4, 1'b0);
    // step 0 acts as 1; equal powers keep the first code
    pwr_tab[5] = 8'd6; pwr_tab[6] = 8'd6; pwr_tab[7] = 8'd6;
    run_sweep(5, 7, 0, 1'b0);
    // start beyond end: single point
    run_sweep(30, 20, 3, 1'b0);

    // abort wins over a simultaneous start in DONE
    i_search_start = 1'b1; i_search_abort = 1'b1;
    tick();
    i_search_start = 1'b0; i_search_abort = 1'b0;
    chk("abort_vs_start_done", {31'd0, o_search_done}, 32'd0);
    chk("abort_vs_start_busy", {31'd0, o_search_busy}, 32'd0);
    chk("abort_vs_start_refresh", {31'd0, o_ctrl_refresh}, 32'd0);

    // abort in COMMIT coinciding with commit_val
    pwr_tab[10] = 8'd3; pwr_tab[15] = 8'd200;
    i_code_start = 8'd10; i_code_end = 8'd20; i_code_step = 8'd5;
    i_search_start = 1'b1;
    tick();
    i_search_start = 1'b0;
    exp_refresh++;
    wait_tune(ok);
    i_ctrl_tune_rdy = 1'b1; tick(); i_ctrl_tune_rdy = 1'b0;
    i_ctrl_commit_val = 1'b1; i_ctrl_ring_tune_commit = 8'd10; i_ctrl_pwr_commit = pwr_tab[10];
    tick();
    i_ctrl_commit_val = 1'b0;
    wait_tune(ok);
    i_ctrl_tune_rdy = 1'b1; tick(); i_ctrl_tune_rdy = 1'b0;
    i_ctrl_commit_val = 1'b1; i_ctrl_ring_tune_commit = 8'd15; i_ctrl_pwr_commit = pwr_tab[15];
    i_search_abort = 1'b1;
    tick();
    i_ctrl_commit_val = 1'b0; i_search_abort = 1'b0;
    chk("abort_busy", {31'd0, o_search_busy}, 32'd0);
    chk("abort_done", {31'd0, o_search_done}, 32'd0);
    chk("abort_commit_rdy", {31'd0, o_ctrl_commit_rdy}, 32'd0);
    chk("abort_peak_pwr", {24'd0, o_peak_pwr}, 32'd3);
    chk("abort_peak_code", {24'd0, o_peak_code}, 32'd10);
    repeat (3) begin
      tick();
      chk("abort_no_tune_val", {31'd0, o_ctrl_tune_val}, 32'd0);
    end

    // randomized windows with a narrow power range to provoke ties
    repeat (4) begin
      fill_random_pwr(15);
      run_sweep($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 20), 1'b0);
    end

    // asynchronous reset in the middle of COMMIT
    i_code_start = 8'd40; i_code_end = 8'd60; i_code_step = 8'd1;
    i_search_start = 1'b1;
    tick();
    i_search_start = 1'b0;
    exp_refresh++;
    wait_tune(ok);
    i_ctrl_tune_rdy = 1'b1; tick(); i_ctrl_tune_rdy = 1'b0;
    chk("pre_rst_commit_rdy", {31'd0, o_ctrl_commit_rdy}, 32'd1);
    i_rst = 1'b1;
    #1;
    chk("async_rst_commit_rdy", {31'd0, o_ctrl_commit_rdy}, 32'd0);
    chk("async_rst_active", {31'd0, o_ctrl_active}, 32'd0);
    chk("async_rst_busy", {31'd0, o_search_busy}, 32'd0);
    chk("async_rst_ring_tune", {24'd0, o_ctrl_ring_tune}, 32'd0);
    chk("async_rst_peak_code", {24'd0, o_peak_code}, 32'd0);
    chk("async_rst_peak_pwr", {24'd0, o_peak_pwr}, 32'd0);
    tick(); tick();
    i_rst = 1'b0;
    tick();
    run_sweep(0, 0, 0, 1'b0);

    tick();
    chk("refresh_count", refresh_cnt, exp_refresh);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
